// File: rtl/dispense_sequencer.sv
// dispense_sequencer
//
// Drives the four product motors one at a time for a purchased product set.
// Each item gets a fixed-length motor pulse, then a bounded wait for the drop
// sensor, then a motor-off settle gap before the next item is considered.
// Completion, per-item failures and the number of confirmed drops are reported
// back to the vending controller.
//
// Ports
//   i_clk            system clock, single domain
//   i_reset          synchronous active-high reset
//   i_start          request to run a sequence, only honoured while idle
//   i_sel[3:0]       product mask captured on an accepted start
//                    ([0] Water, [1] Chips, [2] ProteinBar, [3] Soda)
//   i_drop_sense     synchronised product-drop sensor
//   o_motor[3:0]     one-hot motor enable, same bit order as i_sel
//   o_busy           high from the cycle after an accepted start through FINISH
//   o_done           one-cycle completion pulse
//   o_error          one-cycle pulse with o_done when any item timed out
//   o_fail_mask[3:0] items that timed out, held until the next accepted start
//   o_dispensed_cnt  number of items with a confirmed drop
//   o_cur_item[1:0]  index of the item being or last handled

module dispense_sequencer #(
   parameter int unsigned PULSE_CYCLES   = 50_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
   parameter int unsigned GAP_CYCLES     = 10_000_000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [3:0] i_sel,
   input  logic       i_drop_sense,
   output logic [3:0] o_motor,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error,
   output logic [3:0] o_fail_mask,
   output logic [2:0] o_dispensed_cnt,
   output logic [1:0] o_cur_item
);

   localparam logic [31:0] PULSE_LAST   = 32'(PULSE_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      DRIVE,
      WAIT,
      GAP,
      FINISH
   } stateType;

   stateType    r_state;
   logic [3:0]  r_pending;
   logic [31:0] r_counter;
   logic        r_dropFlag;

   logic [1:0]  w_pickIdx;
   logic [3:0]  w_pickOneHot;
   logic        w_dropSeen;

   // Fixed-priority pick of the next pending item: scanning from the top bit
   // down lets the lowest set bit overwrite, so Water beats Chips beats
   // ProteinBar beats Soda.
   always_comb begin
      w_pickIdx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_pickIdx = 2'(i);
         end
      end
      w_pickOneHot = 4'b0001 << w_pickIdx;
   end

   // A drop on the very last pulse cycle has not yet reached the flag
   // register, so the end-of-pulse decision also looks at the live sensor.
   assign w_dropSeen = r_dropFlag | i_drop_sense;

   // Main sequencer. One shared counter times the pulse, the drop wait and the
   // gap; it is cleared on every state entry that uses it. All outputs are
   // registered here, so the motor only ever changes at a state transition and
   // can never have two bits set.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= IDLE;
         r_pending       <= 4'b0000;
         r_counter       <= 32'd0;
         r_dropFlag      <= 1'b0;
         o_motor         <= 4'b0000;
         o_busy          <= 1'b0;
         o_done          <= 1'b0;
         o_error         <= 1'b0;
         o_fail_mask     <= 4'b0000;
         o_dispensed_cnt <= 3'd0;
         o_cur_item      <= 2'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_pending       <= i_sel;
                  o_fail_mask     <= 4'b0000;
                  o_dispensed_cnt <= 3'd0;
                  o_busy          <= 1'b1;
                  r_state         <= SCAN;
               end
            end

            SCAN: begin
               if (r_pending == 4'b0000) begin
                  o_done  <= 1'b1;
                  o_error <= |o_fail_mask;
                  r_state <= FINISH;
               end else begin
                  o_cur_item <= w_pickIdx;
                  r_pending  <= r_pending & ~w_pickOneHot;
                  o_motor    <= w_pickOneHot;
                  r_counter  <= 32'd0;
                  r_dropFlag <= 1'b0;
                  r_state    <= DRIVE;
               end
            end

            DRIVE: begin
               if (i_drop_sense) begin
                  r_dropFlag <= 1'b1;
               end
               if (r_counter == PULSE_LAST) begin
                  o_motor   <= 4'b0000;
                  r_counter <= 32'd0;
                  if (w_dropSeen) begin
                     o_dispensed_cnt <= o_dispensed_cnt + 3'd1;
                     r_state         <= GAP;
                  end else begin
                     r_state <= WAIT;
                  end
               end else begin
                  r_counter <= r_counter + 32'd1;
               end
            end

            WAIT: begin
               if (i_drop_sense) begin
                  o_dispensed_cnt <= o_dispensed_cnt + 3'd1;
                  r_counter       <= 32'd0;
                  r_state         <= GAP;
               end else if (r_counter == TIMEOUT_LAST) begin
                  o_fail_mask[o_cur_item] <= 1'b1;
                  r_counter               <= 32'd0;
                  r_state                 <= GAP;
               end else begin
                  r_counter <= r_counter + 32'd1;
               end
            end

            GAP: begin
               if (r_counter == GAP_LAST) begin
                  r_counter <= 32'd0;
                  r_state   <= SCAN;
               end else begin
                  r_counter <= r_counter + 32'd1;
               end
            end

            FINISH: begin
               o_done  <= 1'b0;
               o_error <= 1'b0;
               o_busy  <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               o_motor <= 4'b0000;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dispense_sequencer.sv
// tb_dispense_sequencer
//
// Directed bench for dispense_sequencer with short timing parameters
// (pulse 4, timeout 8, gap 2). Cycle numbers below follow the block's own
// convention: the start is accepted at edge 0 and cycle N is the period that
// follows edge N-1. Expected motor windows and done cycles are hand-computed.

module tb_dispense_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] sel   = 4'b0000;
   logic       drop  = 1'b0;

   logic [3:0] motor;
   logic       busy;
   logic       done;
   logic       error;
   logic [3:0] failMask;
   logic [2:0] dispensedCnt;
   logic [1:0] curItem;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   dispense_sequencer #(
      .PULSE_CYCLES  (4),
      .TIMEOUT_CYCLES(8),
      .GAP_CYCLES    (2)
   ) dut (
      .i_clk          (clock),
      .i_reset        (reset),
      .i_start        (start),
      .i_sel          (sel),
      .i_drop_sense   (drop),
      .o_motor        (motor),
      .o_busy         (busy),
      .o_done         (done),
      .o_error        (error),
      .o_fail_mask    (failMask),
      .o_dispensed_cnt(dispensedCnt),
      .o_cur_item     (curItem)
   );

   // One comparison: counts it, and on a miss counts the failure and reports
   // the tag with observed and expected values.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just after the edge so outputs are stable.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic [3:0] sl, input logic dr);
      start = st;
      sel   = sl;
      drop  = dr;
   endtask

   // Runs one complete sequence from an accepted start through FINISH and the
   // first IDLE cycle. dropA/dropB are the cycles where the sensor is high,
   // pokeCyc is a cycle where start is re-asserted with a different mask, and
   // motorA/motorB give the expected 4-cycle motor windows (start 0 = none).
   task automatic runSequence(
      input string      name,
      input logic [3:0] selMask,
      input int         dropA,
      input int         dropB,
      input int         pokeCyc,
      input int         lastCyc,
      input logic [3:0] motorA,
      input int         motorAStart,
      input logic [3:0] motorB,
      input int         motorBStart,
      input int         expCnt,
      input logic [3:0] expFail,
      input int         expItem
   );
      logic [3:0] expMotor;
      applyStimulus(1'b1, selMask, 1'b0);
      tick();
      for (int cyc = 1; cyc <= lastCyc; cyc++) begin
         applyStimulus(cyc == pokeCyc, (cyc == pokeCyc) ? ~selMask : selMask,
                       (cyc == dropA) || (cyc == dropB));
         expMotor = 4'b0000;
         if (motorAStart > 0 && cyc >= motorAStart && cyc < motorAStart + 4) expMotor = motorA;
         if (motorBStart > 0 && cyc >= motorBStart && cyc < motorBStart + 4) expMotor = motorB;
         checkOutput($sformatf("%s motor c%0d", name, cyc), 32'(motor), 32'(expMotor));
         checkOutput($sformatf("%s busy c%0d", name, cyc), 32'(busy), 32'd1);
         checkOutput($sformatf("%s done c%0d", name, cyc), 32'(done), 32'(cyc == lastCyc));
         if (cyc == 1) begin
            checkOutput($sformatf("%s cnt cleared", name), 32'(dispensedCnt), 32'd0);
            checkOutput($sformatf("%s fail cleared", name), 32'(failMask), 32'd0);
         end
         if (cyc == lastCyc) begin
            checkOutput($sformatf("%s cnt", name), 32'(dispensedCnt), 32'(expCnt));
            checkOutput($sformatf("%s fail_mask", name), 32'(failMask), 32'(expFail));
            checkOutput($sformatf("%s error", name), 32'(error), 32'(expFail != 4'b0000));
            checkOutput($sformatf("%s cur_item", name), 32'(curItem), 32'(expItem));
         end
         tick();
      end
      applyStimulus(1'b0, selMask, 1'b0);
      checkOutput($sformatf("%s idle busy", name), 32'(busy), 32'd0);
      checkOutput($sformatf("%s idle done", name), 32'(done), 32'd0);
      checkOutput($sformatf("%s idle error", name), 32'(error), 32'd0);
      checkOutput($sformatf("%s cnt held", name), 32'(dispensedCnt), 32'(expCnt));
      checkOutput($sformatf("%s fail held", name), 32'(failMask), 32'(expFail));
   endtask

   // Directed sequence of scenarios, each starting from IDLE.
   initial begin
      $display("[TB] dispense_sequencer bench start");

      tick();
      tick();
      reset = 1'b0;
      checkOutput("reset motor", 32'(motor), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset error", 32'(error), 32'd0);
      checkOutput("reset fail", 32'(failMask), 32'd0);
      checkOutput("reset cnt", 32'(dispensedCnt), 32'd0);
      checkOutput("reset item", 32'(curItem), 32'd0);

      // Water, drop in 2nd DRIVE cycle, stray drop in GAP, start poke in DRIVE.
      runSequence("single", 4'b0001, 3, 6, 4, 9, 4'b0001, 2, 4'b0000, 0, 1, 4'b0000, 0);

      // Chips then Soda, each drop on WAIT cycle 0.
      runSequence("multi", 4'b1010, 6, 14, -1, 18, 4'b0010, 2, 4'b1000, 10, 2, 4'b0000, 3);

      // ProteinBar never drops: 8-cycle wait then failure.
      runSequence("timeout", 4'b0100, -1, -1, -1, 17, 4'b0100, 2, 4'b0000, 0, 0, 4'b0100, 2);

      // Drop on the final WAIT cycle counts as success.
      runSequence("lastwait", 4'b0001, 13, -1, -1, 17, 4'b0001, 2, 4'b0000, 0, 1, 4'b0000, 0);

      // Empty mask: SCAN then FINISH two cycles after the start edge.
      runSequence("empty", 4'b0000, -1, -1, -1, 2, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);

      // Reset during the 2nd DRIVE cycle of item 0 with all four selected.
      applyStimulus(1'b1, 4'b1111, 1'b0);
      tick();
      applyStimulus(1'b0, 4'b1111, 1'b0);
      tick();
      tick();
      checkOutput("rst mid motor before", 32'(motor), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rst mid motor", 32'(motor), 32'd0);
      checkOutput("rst mid busy", 32'(busy), 32'd0);
      checkOutput("rst mid done", 32'(done), 32'd0);
      checkOutput("rst mid error", 32'(error), 32'd0);
      checkOutput("rst mid fail", 32'(failMask), 32'd0);
      checkOutput("rst mid cnt", 32'(dispensedCnt), 32'd0);
      checkOutput("rst mid item", 32'(curItem), 32'd0);
      for (int cyc = 0; cyc < 20; cyc++) begin
         tick();
         checkOutput($sformatf("post rst motor %0d", cyc), 32'(motor), 32'd0);
         checkOutput($sformatf("post rst busy %0d", cyc), 32'(busy), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dispense_sequencer.md
# dispense_sequencer

Sequences the physical dispense of a purchased product set: once the vending controller has confirmed a purchase, this block drives the four product motors strictly one at a time. It checks each drop against the product-drop sensor with a timeout, then reports completion, failures and the count of items delivered. It sits between the vending FSM's dispense state and the motor driver pins, and it owns the single shared motor supply.

## Interface
- PULSE_CYCLES, 50_000_000: motor-on duration per item, in clk cycles (≥1)
- TIMEOUT_CYCLES, 100_000_000: maximum wait for drop_sense after the motor pulse ends (≥1)
- GAP_CYCLES, 10_000_000: motor-off settle time between items (≥1)

- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high; clears all state on the next clk edge
- start  in  1  request to run a sequence; accepted only in IDLE
- sel  in  4  product mask, sampled on an accepted start: [0] Water, [1] Chips, [2] ProteinBar, [3] Soda
- drop_sense  in  1  drop sensor, already synchronised; any high cycle counts as a drop
- motor  out  4  one-hot motor enable, same bit order as sel; never more than one bit set
- busy  out  1  high from the cycle after an accepted start through the FINISH cycle
- done  out  1  one-cycle pulse in FINISH
- error  out  1  one-cycle pulse coincident with done when fail_mask ≠ 0
- fail_mask  out  4  items that timed out; holds after done; cleared on the next accepted start
- dispensed_cnt  out  3  count of items with a confirmed drop; holds after done; cleared on the next accepted start
- cur_item  out  2  index of the item being or last handled

## Operation
- States: IDLE, SCAN, DRIVE, WAIT, GAP, FINISH. All outputs are registered.
- Reset values: state IDLE, motor 0, busy 0, done 0, error 0, fail_mask 0, dispensed_cnt 0, cur_item 0. Internal pending mask, counter and drop flag are cleared.
- IDLE:
  - start=1 → pending←sel, fail_mask←0, dispensed_cnt←0, busy←1, go to SCAN.
  - start is ignored in every other state.
- SCAN:
  - If pending=0 → FINISH.
  - Otherwise pick the lowest set bit i (fixed priority Water > Chips > ProteinBar > Soda). Set cur_item←i, clear pending[i], motor←1<<i, counter←0, drop flag←0, go to DRIVE.
- DRIVE:
  - Motor stays on for exactly PULSE_CYCLES cycles.
  - drop_sense in any DRIVE cycle sets the drop flag.
  - At the end of the pulse, motor←0. If the flag is set, dispensed_cnt+1 and go to GAP. Otherwise go to WAIT with counter←0.
- WAIT:
  - drop_sense → dispensed_cnt+1, go to GAP.
  - After TIMEOUT_CYCLES cycles with no drop → fail_mask[i]←1, go to GAP.
  - drop_sense on the final timeout cycle counts as success; success wins over timeout.
- GAP: motor off for GAP_CYCLES cycles, then SCAN. drop_sense is ignored in GAP, SCAN, FINISH and IDLE.
- FINISH: done←1, error←|fail_mask, busy stays 1; next edge goes to IDLE with busy←0, done←0, error←0.
- sel changes after acceptance have no effect. sel=0 on start runs SCAN→FINISH: done with cnt 0 and no error.
- Reset mid-sequence: motor drops at that edge and the remaining pending items are discarded.
- Counters: 32-bit unsigned, compared against PARAM−1. dispensed_cnt maximum is 4, so it never wraps.

## Timing
- Edge 0 accepts start. Cycle 1 is SCAN with busy=1. motor is high from cycle 2 for PULSE_CYCLES cycles.
- Per item with a drop during DRIVE: 1 (SCAN) + PULSE_CYCLES + GAP_CYCLES cycles.
- Per item with a drop k cycles into WAIT (k=0 is the first WAIT cycle): adds k+1 cycles.
- Per item that times out: adds TIMEOUT_CYCLES cycles.
- Sequence end: one final SCAN cycle, then FINISH for 1 cycle, then IDLE. A new start can be accepted on the first IDLE cycle.
- Motor handover: at least GAP_CYCLES+1 all-zero motor cycles between any two items.

## Test plan
Bench parameters: PULSE_CYCLES=4, TIMEOUT_CYCLES=8, GAP_CYCLES=2.
- Single item with a drop in DRIVE:
  - Stimulus: sel=0001, start at edge 0, drop_sense in the 2nd DRIVE cycle.
  - Required: motor=0001 in cycles 2–5; done in cycle 9; dispensed_cnt=1, error=0.
- Multiple items, fixed order:
  - Stimulus: sel=1010 (Chips, Soda), every drop arriving in WAIT cycle 0.
  - Required: motor shows 0010 then 1000, never overlapping, with at least 3 zero cycles between them; cnt=2.
- Timeout:
  - Stimulus: sel=0100, no drop_sense.
  - Required: WAIT lasts 8 cycles; fail_mask=0100; error and done pulse together; cnt=0.
- Boundary cases:
  - Drop on the final WAIT cycle: required to count as success.
  - sel=0000 on start: done exactly 2 cycles after the start edge, error=0.
  - start asserted while busy: required to be ignored.
- Reset mid-DRIVE:
  - Stimulus: sel=1111, reset in the 2nd DRIVE cycle of item 0.
  - Required: all outputs at reset values on the next edge; no further motor activity without a new start.
